// File: rtl/divider.sv
// Free-running iterative restoring divider: captures operands, runs N
// shift/subtract steps, then publishes saturated N/2-bit quotient and remainder.
module divider #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   num1,
    input  logic [N-1:0]   num2,
    output logic [N/2-1:0] quotient,
    output logic [N/2-1:0] remainder
);

    localparam int H  = N / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dq_q, dq_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [H-1:0]  quotient_q, quotient_d;
    logic [H-1:0]  remainder_q, remainder_d;

    logic [N:0]    trial_s;
    logic          ge_s;
    logic [N-1:0]  rem_sub_s;
    logic [N-1:0]  rem_step_s;
    logic [N-1:0]  quo_step_s;

    function automatic logic [H-1:0] sat_f(input logic [N-1:0] v);
        if (v[N-1:H] != {(N-H){1'b0}}) begin
            sat_f = {H{1'b1}};
        end else begin
            sat_f = v[H-1:0];
        end
    endfunction

    // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
    assign trial_s    = {rem_q, dq_q[N-1]};
    assign ge_s       = (trial_s >= {1'b0, dvs_q});
    assign rem_sub_s  = trial_s[N-1:0] - dvs_q;
    assign rem_step_s = ge_s ? rem_sub_s : trial_s[N-1:0];
    assign quo_step_s = {dq_q[N-2:0], ge_s};

    // Next-state: capture at cnt=0, one restoring step per cycle, publish at cnt=N
    always_comb begin
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (cnt_q == CNT_ZERO) begin
            dq_d  = num1;
            dvs_d = num2;
            rem_d = {N{1'b0}};
            cnt_d = CNT_ONE;
        end else begin
            dq_d  = quo_step_s;
            rem_d = rem_step_s;
            if (cnt_q == CNT_LAST) begin
                quotient_d = sat_f(quo_step_s);
                // divide-by-zero leaves the whole dividend in the remainder; report its low half
                if (dvs_q == {N{1'b0}}) begin
                    remainder_d = rem_step_s[H-1:0];
                end else begin
                    remainder_d = sat_f(rem_step_s);
                end
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt_q       <= CNT_ZERO;
            dq_q        <= {N{1'b0}};
            dvs_q       <= {N{1'b0}};
            rem_q       <= {N{1'b0}};
            quotient_q  <= {H{1'b0}};
            remainder_q <= {H{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: driver pushes reference results, monitor
// tracks the operation period and compares outputs every cycle.
module tb_divider;

    localparam int N = 4;
    localparam int H = N / 2;

    typedef struct packed {
        logic [H-1:0] q;
        logic [H-1:0] r;
    } exp_t;

    logic         clk;
    logic         rstn;
    logic [N-1:0] num1;
    logic [N-1:0] num2;
    logic [H-1:0] quotient;
    logic [H-1:0] remainder;

    exp_t exp_q[$];
    exp_t hold;
    int   compared   = 0;
    int   mismatched = 0;
    int   phase      = 0;
    bit   seen_rst   = 1'b0;
    bit   done       = 1'b0;

    divider #(.N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .num1      (num1),
        .num2      (num2),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_div(input int unsigned a, input int unsigned b);
        exp_t e;
        int unsigned qt, rt, lim;
        lim = 1 << H;
        if (b == 0) begin
            e.q = '1;
            e.r = H'(a % lim);
        end else begin
            qt  = a / b;
            rt  = a % b;
            e.q = (qt < lim) ? H'(qt) : '1;
            e.r = (rt < lim) ? H'(rt) : '1;
        end
        return e;
    endfunction

    // One full period; operands are scrambled after capture and must be ignored
    task automatic run_op(input int unsigned a, input int unsigned b);
        num1 = N'(a);
        num2 = N'(b);
        exp_q.push_back(ref_div(a, b));
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            #1;
            num1 = N'($urandom);
            num2 = N'($urandom);
            @(posedge clk);
        end
        #1;
    endtask

    // Start an operation and hit it with a one-edge reset at cnt=k
    task automatic abort_op(input int unsigned a, input int unsigned b, input int k);
        num1 = N'(a);
        num2 = N'(b);
        exp_q.push_back(ref_div(a, b));
        @(posedge clk);
        repeat (k - 1) @(posedge clk);
        #1;
        rstn = 1'b1;
        num1 = N'($urandom);
        @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    // Monitor: track period from reset, pop expected on result edges, compare every cycle
    always begin
        @(posedge clk);
        if (rstn) begin
            seen_rst = 1'b1;
            phase    = 0;
            hold     = '0;
            exp_q.delete();
        end else if (seen_rst) begin
            if (phase == N) begin
                phase = 0;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL scoreboard_empty: result edge with no expected entry at %0t", $time);
                end else begin
                    hold = exp_q.pop_front();
                end
            end else begin
                phase++;
            end
        end
        #2;
        if (seen_rst && !done) begin
            compared++;
            if (quotient !== hold.q) begin
                mismatched++;
                $display("FAIL quotient: got %b expected %b at %0t", quotient, hold.q, $time);
            end
            compared++;
            if (remainder !== hold.r) begin
                mismatched++;
                $display("FAIL remainder: got %b expected %b at %0t", remainder, hold.r, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1;
        num1 = '0;
        num2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;

        run_op(9, 3);
        run_op(7, 2);
        run_op(5, 3);
        run_op(12, 3);
        run_op(6, 0);
        run_op(15, 1);
        run_op(0, 0);
        run_op(15, 15);
        run_op(3, 7);
        abort_op(14, 3, 3);
        run_op(11, 2);
        abort_op(9, 1, N);
        run_op(13, 4);
        for (int i = 0; i < 60; i++) begin
            run_op($urandom_range(0, (1 << N) - 1), $urandom_range(0, (1 << N) - 1));
        end
        abort_op($urandom_range(0, (1 << N) - 1), $urandom_range(1, (1 << N) - 1), 2);
        run_op(10, 3);

        repeat (2) @(posedge clk);
        #3;
        done = 1'b1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits; even and >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset; synchronous and active-high, so rstn=1 at a rising clk edge resets the block.
REQ-004 SHALL have port num1  input  N  unsigned dividend.
REQ-005 SHALL have port num2  input  N  unsigned divisor.
REQ-006 SHALL have port quotient  output  N/2  registered quotient result.
REQ-007 SHALL have port remainder  output  N/2  registered remainder result.
REQ-008 SHALL have no other ports, so there is no start/done handshake.

Function
REQ-009 SHALL run free as an iterative restoring divider with an internal step counter cnt from 0 to N; one full operation takes N+1 clock cycles.
REQ-010 SHALL, on the edge where cnt=0, capture num1/num2 into internal registers, clear the N-bit partial remainder and advance cnt.
REQ-011 SHALL, on each edge where cnt=1..N, perform one restoring step, MSB of the captured dividend first:
  - shift in the next dividend bit;
  - subtract the divisor if the partial remainder is >= divisor;
  - shift in 1 if the subtraction happened, else 0.
REQ-012 SHALL, on the edge where cnt=N, write the results to quotient/remainder and return cnt to 0; the next capture is therefore on the following edge.
REQ-013 SHALL hold quotient/remainder constant between result writes, including throughout a computation.
REQ-014 SHALL ignore num1/num2 changes while cnt!=0; a new operand takes effect at the next cnt=0 capture.
REQ-015 SHALL, for the full N-bit true quotient Q=floor(num1/num2), drive quotient=Q when Q < 2^(N/2), else all-ones (saturation).
REQ-016 SHALL, for the true remainder R=num1 mod num2, drive remainder=R when R < 2^(N/2), else all-ones.
REQ-017 SHALL treat num2=0 as divide-by-zero: quotient=all-ones, remainder=num1[N/2-1:0]; no exception or hang, and the normal cycle count applies.
REQ-018 SHALL keep all arithmetic unsigned, with an N-bit internal partial remainder and N-bit internal quotient; truncation to N/2 bits applies only at the output via REQ-015/REQ-016.
REQ-019 SHALL be purely synchronous, with no combinational path from num1/num2 to the outputs.

Reset
REQ-020 SHALL, on any edge with rstn=1, set quotient=0, remainder=0, cnt=0 and clear all working registers.
REQ-021 SHALL, when rstn=1 arrives mid-operation, abandon the operation without updating the outputs from it.
REQ-022 SHALL perform the first capture on the first edge with rstn=0 after reset; that operation's result appears on the edge N cycles later.
REQ-023 SHALL let reset take priority over the cnt=N result write when both occur on the same edge.

Verification
REQ-024 SHALL cover, with N=4: num1=9, num2=3, reset released -> after 5 edges quotient=2'b11, remainder=2'b00; outputs stay 0 for the first 4 edges.
REQ-025 SHALL cover, with N=4: num1=7, num2=2 -> quotient=2'b11, remainder=2'b01; then num1=5, num2=3 -> quotient=2'b01, remainder=2'b10 one full period later.
REQ-026 SHALL cover, with N=4: num1=12, num2=3 -> true quotient 4 saturates, giving quotient=2'b11, remainder=2'b00.
REQ-027 SHALL cover, with N=4: num1=6, num2=0 -> quotient=2'b11, remainder=2'b10.
REQ-028 SHALL cover: num2 changed at cnt=2 -> result reflects the captured operands; the new operand appears only in the next period's result.
REQ-029 SHALL cover: rstn=1 for one edge at cnt=3 -> outputs 0 on that edge; a fresh capture occurs on the next edge, with the result N edges after that.
